cdb_result_arbiter: RTL

- Registered two-source arbiter that merges the 65-bit result streams of two execution units (bit 64 = result tag-valid flag, bits 63:0 = result data) onto one common-data-bus (CDB) stage.
- Sits directly downstream of the 65-bit 2:1 NAND mux. It generates the mux `select`/`invSelect` pair from its round-robin grant and captures the mux output into the CDB pipeline register.
- Provides ready/valid back-pressure to both producers and carries per-source grant statistics for performance debug.

---
 rtl/cdb_result_arbiter_if.sv | 34 +++
 rtl/cdb_result_arbiter.sv | 78 +++++++
 2 files changed

// File: rtl/cdb_result_arbiter_if.sv
// rtl/cdb_result_arbiter_if.sv - producer, mux, CDB and statistics signals of the CDB result arbiter
interface cdb_result_arbiter_if #(
  parameter int WIDTH = 65,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             mux_select;
  logic             mux_inv_select;
  logic [WIDTH-1:0] mux_out;
  logic             cdb_valid;
  logic [WIDTH-1:0] cdb_data;
  logic             cdb_ready;
  logic [CNT_W-1:0] grant0_cnt;
  logic [CNT_W-1:0] grant1_cnt;
  logic [CNT_W-1:0] conflict_cnt;

  modport slave (
    input  flush, req0_valid, req0_data, req1_valid, req1_data, mux_out, cdb_ready,
    output req0_ready, req1_ready, mux_select, mux_inv_select,
    output cdb_valid, cdb_data, grant0_cnt, grant1_cnt, conflict_cnt
  );

  modport master (
    output flush, req0_valid, req0_data, req1_valid, req1_data, mux_out, cdb_ready,
    input  req0_ready, req1_ready, mux_select, mux_inv_select,
    input  cdb_valid, cdb_data, grant0_cnt, grant1_cnt, conflict_cnt
  );
endinterface

// File: rtl/cdb_result_arbiter.sv
// rtl/cdb_result_arbiter.sv - round-robin two-source arbiter driving the result mux and the CDB register
module cdb_result_arbiter #(
  parameter int WIDTH = 65,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  cdb_result_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             cdb_valid_q;
  logic [WIDTH-1:0] cdb_data_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] grant0_q;
  logic [CNT_W-1:0] grant1_q;
  logic [CNT_W-1:0] conflict_q;

  logic both_valid;
  logic any_valid;
  logic grant;
  logic can_load;
  logic xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    both_valid = bus.req0_valid & bus.req1_valid;
    any_valid  = bus.req0_valid | bus.req1_valid;
    // With no requester the previous grant is kept so the mux select does not toggle.
    if (both_valid)
      grant = ~last_grant_q;
    else if (bus.req0_valid)
      grant = 1'b0;
    else if (bus.req1_valid)
      grant = 1'b1;
    else
      grant = last_grant_q;
    // Reset is folded in so no producer sees a handshake while the register is being cleared.
    can_load = reset_n & ~bus.flush & (~cdb_valid_q | bus.cdb_ready);
    xfer     = can_load & any_valid;
  end

  assign bus.mux_select     = grant;
  assign bus.mux_inv_select = ~grant;
  assign bus.req0_ready     = can_load & bus.req0_valid & ~grant;
  assign bus.req1_ready     = can_load & bus.req1_valid & grant;
  assign bus.cdb_valid      = cdb_valid_q;
  assign bus.cdb_data       = cdb_data_q;
  assign bus.grant0_cnt     = grant0_q;
  assign bus.grant1_cnt     = grant1_q;
  assign bus.conflict_cnt   = conflict_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cdb_valid_q  <= 1'b0;
      cdb_data_q   <= '0;
      last_grant_q <= 1'b1;
      grant0_q     <= '0;
      grant1_q     <= '0;
      conflict_q   <= '0;
    end else if (xfer) begin
      cdb_valid_q  <= 1'b1;
      cdb_data_q   <= bus.mux_out;
      last_grant_q <= grant;
      if (grant)
        grant1_q <= sat_inc(grant1_q);
      else
        grant0_q <= sat_inc(grant0_q);
      if (both_valid)
        conflict_q <= sat_inc(conflict_q);
    end else if (cdb_valid_q && (bus.flush || bus.cdb_ready)) begin
      cdb_valid_q <= 1'b0;
    end
  end
endmodule
